fp_div_iter: RTL and testbench

- Parametrised, multi-cycle IEEE-754-style floating-point divider. Successor to the single-cycle combinational FP divider in the FP ALU.
- Quotient mantissa is produced by radix-2 restoring division, one bit per clock.
- Valid/ready handshakes on both input and output, so the block sits in a pipelined ALU datapath.
- Field widths are parametric: single precision by default, half and double by parameter.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_div_iter.sv | 190 +++++++++++++++++++
 tb/tb_fp_div_iter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP helpers: FSM encodings, exponent constants and field extraction.
// Used by the iterative divider and intended for the iterative multiplier.
package fp_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_NORM = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_PACK = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [63:0] EXC_ONES = '1;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic [63:0] fld_exp(input logic [63:0] w, input int exp_w, input int man_w);
    return (w >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fld_man(input logic [63:0] w, input int man_w);
    return w & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic fld_sign(input logic [63:0] w, input int exp_w, input int man_w);
    return 1'((w >> (exp_w + man_w)) & 64'd1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametric leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int W = 24,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  output logic [CW-1:0] cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (x[i]) cnt = CW'(W - 1 - i);
  end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle FP divider: restoring radix-2, one quotient bit per clock.
// FP_DIV_RNE_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     exception,
  output logic                     div_by_zero
);

  localparam int FW      = 1 + EXP_W + MAN_W;
  localparam int M_W     = MAN_W + 1;
  localparam int R_W     = MAN_W + 2;
  localparam int Q_W     = MAN_W + 3;
  localparam int E_W     = EXP_W + 2;
  localparam int CW      = $clog2(M_W + 1);
  localparam int NW      = $clog2(Q_W);
  localparam int BIAS    = bias_of(EXP_W);
  localparam int EXP_MAX = exp_max_of(EXP_W);

  logic [2:0]     state;
  logic [FW-1:0]  a_r, b_r;
  logic           exc_r, dbz_r, az_r;
  logic [E_W-1:0] e_r;
  logic [R_W-1:0] rem_r;
  logic [Q_W-1:0] q_r;
  logic [M_W-1:0] mb_r;
  logic [NW-1:0]  cnt_r;

  assign in_ready  = (state == ST_IDLE) & ~rst;
  assign out_valid = (state == ST_DONE) & ~rst;

  // Operand unpack and normalisation, consumed in NORM.
  logic [EXP_W-1:0] ea_f, eb_f, ea_e, eb_e;
  logic [MAN_W-1:0] ma_f, mb_f;
  logic             a_sub, b_sub, a_zero, b_zero, exc_n, dbz_n, ge0;
  logic [M_W-1:0]   ma_x, mb_x, na, nb, rem0;
  logic [CW-1:0]    sh_a, sh_b;
  logic [E_W-1:0]   e_n;

  fp_lzc #(.W(M_W)) u_lzc_a (.x(ma_x), .cnt(sh_a));
  fp_lzc #(.W(M_W)) u_lzc_b (.x(mb_x), .cnt(sh_b));

  always_comb begin
    ea_f   = EXP_W'(fld_exp(64'(a_r), EXP_W, MAN_W));
    eb_f   = EXP_W'(fld_exp(64'(b_r), EXP_W, MAN_W));
    ma_f   = MAN_W'(fld_man(64'(a_r), MAN_W));
    mb_f   = MAN_W'(fld_man(64'(b_r), MAN_W));
    a_sub  = (ea_f == '0);
    b_sub  = (eb_f == '0);
    a_zero = a_sub && (ma_f == '0);
    b_zero = b_sub && (mb_f == '0);
    exc_n  = (&ea_f) | (&eb_f) | b_zero;
    dbz_n  = b_zero & ~(&ea_f);
    ea_e   = a_sub ? EXP_W'(1) : ea_f;
    eb_e   = b_sub ? EXP_W'(1) : eb_f;
    ma_x   = {~a_sub, ma_f};
    mb_x   = {~b_sub, mb_f};
    na     = ma_x << sh_a;
    nb     = mb_x << sh_b;
    e_n    = E_W'(ea_e) - E_W'(eb_e) + E_W'(BIAS) - E_W'(sh_a) + E_W'(sh_b);
    // First quotient bit is resolved here so DIV needs one cycle fewer.
    ge0    = (na >= nb);
    rem0   = ge0 ? (na - nb) : na;
  end

  // One restoring step per DIV cycle.
  logic [R_W-1:0] dsr, rdiff;
  logic           ge;

  always_comb begin
    dsr   = {1'b0, mb_r};
    ge    = (rem_r >= dsr);
    rdiff = ge ? (rem_r - dsr) : rem_r;
  end

  // Normalise, round and classify, consumed in PACK.
  logic             norm_hi, sticky, rnd_up, sgn, ovf_n, unf_n;
  logic [Q_W-1:0]   qn;
  logic [M_W-1:0]   mant;
  logic [M_W:0]     mant_sum;
  logic [E_W-1:0]   e1, e2;
  logic [MAN_W-1:0] man_o;
  logic [FW-1:0]    res_n;
  logic             pack_unused;

  always_comb begin
    norm_hi  = q_r[Q_W-1];
    qn       = norm_hi ? q_r : {q_r[Q_W-2:0], 1'b0};
    e1       = norm_hi ? e_r : e_r - E_W'(1);
    mant     = qn[Q_W-1:2];
    sticky   = |rem_r;
`ifdef FP_DIV_RNE_EN
    rnd_up   = qn[1] & (qn[0] | sticky | mant[0]);
`else
    rnd_up   = 1'b0;
`endif
    // Carry-out leaves 10..0, i.e. hidden bit set and a zero fraction.
    mant_sum = {1'b0, mant} + (M_W+1)'(rnd_up);
    e2       = mant_sum[M_W] ? e1 + E_W'(1) : e1;
    man_o    = mant_sum[MAN_W-1:0];
    sgn      = fld_sign(64'(a_r), EXP_W, MAN_W) ^ fld_sign(64'(b_r), EXP_W, MAN_W);
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    if (exc_r)
      res_n = FW'(EXC_ONES);
    else if (az_r)
      res_n = {sgn, {(FW-1){1'b0}}};
    else if (!e2[E_W-1] && (e2 >= E_W'(EXP_MAX))) begin
      ovf_n = 1'b1;
      res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e2[E_W-1] || (e2 == '0)) begin
      unf_n = 1'b1;
      res_n = {sgn, {(FW-1){1'b0}}};
    end else
      res_n = {sgn, e2[EXP_W-1:0], man_o};
  end

  assign pack_unused = ^{qn[1:0], sticky, mant_sum[MAN_W], rdiff[R_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      exc_r       <= 1'b0;
      dbz_r       <= 1'b0;
      az_r        <= 1'b0;
      e_r         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      mb_r        <= '0;
      cnt_r       <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      exception   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          state <= ST_NORM;
        end
        ST_NORM: begin
          exc_r <= exc_n;
          dbz_r <= dbz_n;
          az_r  <= a_zero;
          e_r   <= e_n;
          mb_r  <= nb;
          rem_r <= {rem0, 1'b0};
          q_r   <= Q_W'(ge0);
          cnt_r <= NW'(1);
          state <= exc_n ? ST_PACK : ST_DIV;
        end
        ST_DIV: begin
          rem_r <= {rdiff[R_W-2:0], 1'b0};
          q_r   <= {q_r[Q_W-2:0], ge};
          cnt_r <= cnt_r + NW'(1);
          if (cnt_r == NW'(Q_W - 1)) state <= ST_PACK;
        end
        ST_PACK: begin
          result      <= res_n;
          overflow    <= ovf_n;
          underflow   <= unf_n;
          exception   <= exc_r;
          div_by_zero <= dbz_r;
          state       <= ST_DONE;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter (single precision): directed plan cases plus
// random operands against an exact-arithmetic reference model.
module tb_fp_div_iter;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, overflow, underflow, exception, div_by_zero;
  logic [31:0] a = '0, b = '0, result;

  always #5 clk = ~clk;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, exception, div_by_zero}
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0;
  bit   rand_ready = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact quotient via wide integer division, then pack by IEEE rules.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
    int ex, ey, ea, eb, p, bexp;
    logic s;
    logic [127:0] av, bv, num, q, rm;
    logic [24:0] m;
`ifdef FP_DIV_RNE_EN
    logic g, low;
`endif
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    f  = 4'b0000;
    if (ex == 255 || ey == 255 || y[30:0] == 31'd0) begin
      r    = 32'hFFFF_FFFF;
      f[1] = 1'b1;
      f[0] = (y[30:0] == 31'd0) && (ex != 255);
      return;
    end
    av   = 128'({ex != 0, x[22:0]});
    bv   = 128'({ey != 0, y[22:0]});
    ea   = (ex == 0 ? 1 : ex) - 150;
    eb   = (ey == 0 ? 1 : ey) - 150;
    num  = av << 60;
    q    = num / bv;
    rm   = num % bv;
    p    = 0;
    for (int i = 0; i < 128; i++) if (q[i]) p = i;
    bexp = p - 60 + ea - eb + 127;
    m    = 25'(q >> (p - 23));
`ifdef FP_DIV_RNE_EN
    g    = q[7'(p - 24)];
    low  = (rm != 0) || ((q & ((128'd1 << (p - 24)) - 128'd1)) != 0);
    if (g && (low || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m    = m >> 1;
      bexp = bexp + 1;
    end
`endif
    if (bexp >= 255) begin
      r = {s, 8'hFF, 23'd0}; f[3] = 1'b1;
    end else if (bexp <= 0) begin
      r = {s, 31'd0}; f[2] = 1'b1;
    end else
      r = {s, 8'(bexp), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input bit is_b);
    int sel;
    logic [7:0]  e;
    logic [22:0] mn;
    sel = int'($urandom_range(15));
    mn  = 23'($urandom);
    if (sel == 0) begin
      e = 8'd0;
      if (mn == 23'd0) mn = 23'd1;
    end else if (sel == 1) e = 8'hFF;
    else if (sel == 2) e = 8'($urandom_range(4, 1));
    else if (sel == 3) e = 8'($urandom_range(254, 250));
    else e = 8'($urandom_range(254, 1));
    if (is_b && sel == 15) begin
      e = 8'd0; mn = 23'd0;
    end
    return {1'($urandom), e, mn};
  endfunction

  // Drives one operand pair; returns after the accept edge with the expectation queued.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input logic [3:0] f, output int waits);
    exp_t e;
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; waits = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(waits), 64'd0);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    e.res = r; e.flg = f; e.acc = cyc; e.lat = f[1] ? 3 : 28;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: pops on each output handshake; latency counts the accept cycle as cycle 1.
  initial begin
    bit seen = 0;
    int first = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) seen = 0;
      else begin
        if (!seen) begin
          seen  = 1;
          first = cyc;
        end
        if (out_ready) begin
          if (sbq.size() == 0) check("unexpected_output", 64'(result), 64'd0);
          else begin
            e = sbq.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("flags", 64'({overflow, underflow, exception, div_by_zero}), 64'(e.flg));
            check("latency", 64'(first - e.acc + 1), 64'(e.lat));
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_a [7] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                             32'h7F000000, 32'h80800000, 32'h00400000};
  logic [31:0] dir_b [7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h3F800000,
                             32'h3E800000, 32'h4B000000, 32'h3F000000};
`ifdef FP_DIV_RNE_EN
  logic [31:0] dir_r [7] = '{32'h40400000, 32'h3EAAAAAB, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h7F800000, 32'h80000000, 32'h00800000};
`else
  logic [31:0] dir_r [7] = '{32'h40400000, 32'h3EAAAAAA, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h7F800000, 32'h80000000, 32'h00800000};
`endif
  logic [3:0]  dir_f [7] = '{4'b0000, 4'b0000, 4'b0011, 4'b0010, 4'b1000, 4'b0100, 4'b0000};

  initial begin
    int w, stale;
    logic [31:0] x, y, r;
    logic [3:0]  f;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({overflow, underflow, exception, div_by_zero}), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) send(dir_a[i], dir_b[i], dir_r[i], dir_f[i], w);
    drain();

    // Output backpressure: result held, new operands ignored, then immediate re-accept.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, w);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("hold_out_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
      @(negedge clk);
      check("hold_result", 64'(result), 64'h40400000);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    send(32'h40000000, 32'h40000000, 32'h3F800000, 4'b0000, w);
    check("reaccept_wait", 64'(w), 64'd0);
    drain();

    // Reset while DIV is iterating: operation abandoned with no stale output.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, w);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    #1;
    check("midrst_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_stale", 64'(stale), 64'd0);
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, w);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      x = rnd_op(1'b0);
      y = rnd_op(1'b1);
      ref_div(x, y, r, f);
      send(x, y, r, f, w);
    end
    drain();
    rand_ready = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
